// File: rtl/vram_arbiter.sv
// Glyph RAM arbiter: display reads win, buffered writes commit in vblank.
// Writes drain in order from a small FIFO through the single RAM port.
module vram_arbiter #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int VBLANK_ONLY = 1,
    parameter int F_VISIBLE   = 480
) (
    input  logic                          clk,
    input  logic                          sys_rst,
    input  logic [9:0]                    vertPos,
    input  logic                          disp_req,
    input  logic [ADDR_W-1:0]             disp_addr,
    output logic [DATA_W-1:0]             disp_data,
    output logic                          disp_valid,
    input  logic                          wr_valid,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_wdata,
    input  logic [DATA_W-1:0]             ram_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic [7:0]                    frame_cnt,
    output logic                          upd_done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

    typedef enum logic {ACTIVE, BLANK} state_t;

    state_t            state, state_nxt;
    logic              vblank_q;
    logic              blank_entry;
    logic              wgate;
    logic              push;
    logic              full;
    logic              empty;
    logic [PW:0]       count;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [ADDR_W-1:0] fa [FIFO_DEPTH];
    logic [DATA_W-1:0] fd [FIFO_DEPTH];

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push     = wr_valid && !full;
    assign wr_ready = !full;
    assign pending  = count;
    assign disp_data = ram_rdata;

    // FSM: state register
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            vblank_q <= 1'b0;
            state    <= ACTIVE;
        end else begin
            vblank_q <= (vertPos >= 10'(F_VISIBLE));
            state    <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ACTIVE:  if (vblank_q)  state_nxt = BLANK;
            BLANK:   if (!vblank_q) state_nxt = ACTIVE;
            default: state_nxt = ACTIVE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        blank_entry = (state == ACTIVE) && (state_nxt == BLANK);
        wgate = ((state == BLANK) || (VBLANK_ONLY == 0)) &&
                !disp_req && !empty;
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = fa[rd_ptr];
        ram_wdata = fd[rd_ptr];
        if (disp_req) begin
            ram_en   = 1'b1;
            ram_addr = disp_addr;
        end else if (wgate) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fa[wr_ptr] <= wr_addr;
            fd[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + PW'(1);
            if (wgate) rd_ptr <= rd_ptr + PW'(1);
            case ({push, wgate})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Pulse only when the last entry leaves during blanking.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            disp_valid <= 1'b0;
            frame_cnt  <= '0;
            upd_done   <= 1'b0;
        end else begin
            disp_valid <= disp_req;
            if (blank_entry) frame_cnt <= frame_cnt + 8'd1;
            upd_done <= wgate && (state == BLANK) &&
                        (count == (PW+1)'(1)) && !push;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model, write/read scoreboards,
// per-scenario tasks for both commit policies.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;

    logic [9:0]  vert = '0;
    logic        disp_req = 1'b0;
    logic [10:0] disp_addr = '0;
    logic        wr_valid = 1'b0;
    logic [10:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [7:0]  disp_data;
    logic        disp_valid, wr_ready, ram_en, ram_we;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;
    logic [2:0]  pending;
    logic [7:0]  frame_cnt;
    logic        upd_done;

    logic [9:0]  vert1 = '0;
    logic        disp_req1 = 1'b0;
    logic [10:0] disp_addr1 = '0;
    logic        wr_valid1 = 1'b0;
    logic [10:0] wr_addr1 = '0;
    logic [7:0]  wr_data1 = '0;
    logic [7:0]  disp_data1;
    logic        disp_valid1, wr_ready1, ram_en1, ram_we1;
    logic [10:0] ram_addr1;
    logic [7:0]  ram_wdata1;
    logic [7:0]  ram_rdata1 = '0;
    logic [2:0]  pending1;
    logic [7:0]  frame_cnt1;
    logic        upd_done1;

    int n_cmp = 0;
    int n_err = 0;

    logic [18:0] wq[$];
    logic [7:0]  rq[$];
    logic [7:0]  wmem[int];

    always #5 clk = ~clk;

    vram_arbiter #(.VBLANK_ONLY(1)) u0 (
        .clk(clk), .sys_rst(sys_rst), .vertPos(vert),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .pending(pending),
        .frame_cnt(frame_cnt), .upd_done(upd_done)
    );

    vram_arbiter #(.VBLANK_ONLY(0)) u1 (
        .clk(clk), .sys_rst(sys_rst), .vertPos(vert1),
        .disp_req(disp_req1), .disp_addr(disp_addr1),
        .disp_data(disp_data1), .disp_valid(disp_valid1),
        .wr_valid(wr_valid1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .wr_ready(wr_ready1), .ram_en(ram_en1), .ram_we(ram_we1),
        .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
        .ram_rdata(ram_rdata1), .pending(pending1),
        .frame_cnt(frame_cnt1), .upd_done(upd_done1)
    );

    function automatic logic [7:0] pat(input logic [10:0] a);
        return a[7:0] ^ 8'h5A ^ {5'b0, a[10:8]};
    endfunction

    // Synchronous-read RAM model; unwritten cells hold a fixed pattern
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) wmem[int'(ram_addr)] = ram_wdata;
            else ram_rdata <= wmem.exists(int'(ram_addr)) ?
                              wmem[int'(ram_addr)] : pat(ram_addr);
        end
    end

    // Scoreboard: push on accepted stimulus, pop on DUT output
    always @(negedge clk) begin
        logic [18:0] ew;
        logic [7:0]  er;
        if (!sys_rst) begin
            if (wr_valid && wr_ready) wq.push_back({wr_addr, wr_data});
            if (disp_req) rq.push_back(pat(disp_addr));
            if (ram_en && ram_we) begin
                n_cmp++;
                if (wq.size() == 0) begin
                    n_err++;
                    $display("FAIL wr_unexpected addr=%h data=%h",
                             ram_addr, ram_wdata);
                end else begin
                    ew = wq.pop_front();
                    if ({ram_addr, ram_wdata} !== ew) begin
                        n_err++;
                        $display("FAIL wr_commit got=%h/%h exp=%h/%h",
                                 ram_addr, ram_wdata, ew[18:8], ew[7:0]);
                    end
                end
            end
            if (disp_valid) begin
                n_cmp++;
                if (rq.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_unexpected data=%h", disp_data);
                end else begin
                    er = rq.pop_front();
                    if (disp_data !== er) begin
                        n_err++;
                        $display("FAIL rd_data got=%h exp=%h", disp_data, er);
                    end
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic settle_active();
        vert = 10'd100;
        repeat (3) nxt();
    endtask

    task automatic test_reset();
        smp();
        n_cmp++;
        if (disp_valid !== 1'b0 || upd_done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_flags got=%b%b exp=00", disp_valid, upd_done);
        end
        n_cmp++;
        if (pending !== 3'd0 || wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_fifo got=%0d/%b exp=0/1", pending, wr_ready);
        end
        n_cmp++;
        if (frame_cnt !== 8'd0 || ram_en !== 1'b0 || ram_we !== 1'b0) begin
            n_err++;
            $display("FAIL rst_port got=%0d/%b%b exp=0/00",
                     frame_cnt, ram_en, ram_we);
        end
        nxt();
        sys_rst = 1'b0;
        settle_active();
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 11'h200 + 11'(i);
            wr_data  = 8'h30 + 8'(i);
            nxt();
        end
        wr_valid = 1'b0;
        smp();
        n_cmp++;
        if (pending !== 3'd3) begin
            n_err++;
            $display("FAIL rst_pre_pending got=%0d exp=3", pending);
        end
        @(posedge clk);
        #3 sys_rst = 1'b1;
        #1;
        n_cmp++;
        if (pending !== 3'd0 || wr_ready !== 1'b1 || frame_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL rst_mid got=%0d/%b/%0d exp=0/1/0",
                     pending, wr_ready, frame_cnt);
        end
        wq.delete();
        rq.delete();
        nxt();
        sys_rst = 1'b0;
        vert = 10'd480;
        repeat (6) nxt();
        smp();
        n_cmp++;
        if (pending !== 3'd0 || frame_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL rst_after got=%0d/%0d exp=0/1", pending, frame_cnt);
        end
        nxt();
        settle_active();
    endtask

    task automatic test_priority();
        int bad;
        bad = 0;
        vert = 10'd480;
        repeat (2) nxt();
        for (int i = 0; i < 5; i++) begin
            disp_req  = 1'b1;
            disp_addr = 11'h010 + 11'(i);
            wr_valid  = (i < 2);
            wr_addr   = 11'h300 + 11'(i);
            wr_data   = 8'hC0 + 8'(i);
            smp();
            if (ram_we !== 1'b0) bad++;
            nxt();
        end
        disp_req = 1'b0;
        wr_valid = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL prio_no_we got=%0d exp=0", bad);
        end
        smp();
        n_cmp++;
        if (ram_we !== 1'b1 || disp_valid !== 1'b1 || pending !== 3'd2) begin
            n_err++;
            $display("FAIL prio_drain1 got=%b/%b/%0d exp=1/1/2",
                     ram_we, disp_valid, pending);
        end
        nxt();
        smp();
        n_cmp++;
        if (ram_we !== 1'b1 || disp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL prio_drain2 got=%b/%b exp=1/0", ram_we, disp_valid);
        end
        nxt();
        smp();
        n_cmp++;
        if (pending !== 3'd0 || upd_done !== 1'b1 || rq.size() != 0) begin
            n_err++;
            $display("FAIL prio_done got=%0d/%b/%0d exp=0/1/0",
                     pending, upd_done, rq.size());
        end
        nxt();
        settle_active();
    endtask

    task automatic test_deferral();
        logic [7:0] fc;
        int bad;
        bad = 0;
        fc = frame_cnt;
        wr_valid = 1'b1;
        wr_addr  = 11'h123;
        wr_data  = 8'hAB;
        nxt();
        wr_valid = 1'b0;
        smp();
        n_cmp++;
        if (pending !== 3'd1 || ram_we !== 1'b0) begin
            n_err++;
            $display("FAIL defer_hold got=%0d/%b exp=1/0", pending, ram_we);
        end
        for (int i = 0; i < 4; i++) begin
            nxt();
            if (i == 3) vert = 10'd480;
            smp();
            if (ram_we !== 1'b0) bad++;
        end
        nxt();
        smp();
        if (ram_we !== 1'b0) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL defer_early_we got=%0d exp=0", bad);
        end
        nxt();
        smp();
        n_cmp++;
        if (ram_we !== 1'b1 || ram_addr !== 11'h123 || ram_wdata !== 8'hAB) begin
            n_err++;
            $display("FAIL defer_commit got=%b/%h/%h exp=1/123/ab",
                     ram_we, ram_addr, ram_wdata);
        end
        n_cmp++;
        if (frame_cnt !== fc + 8'd1) begin
            n_err++;
            $display("FAIL defer_frame got=%0d exp=%0d", frame_cnt, fc + 8'd1);
        end
        nxt();
        smp();
        n_cmp++;
        if (upd_done !== 1'b1 || pending !== 3'd0) begin
            n_err++;
            $display("FAIL defer_done got=%b/%0d exp=1/0", upd_done, pending);
        end
        nxt();
        smp();
        n_cmp++;
        if (upd_done !== 1'b0) begin
            n_err++;
            $display("FAIL defer_pulse got=%b exp=0", upd_done);
        end
        nxt();
        settle_active();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 11'h400 + 11'(i);
            wr_data  = 8'h50 + 8'(i);
            if (i < 4) nxt();
        end
        smp();
        n_cmp++;
        if (wr_ready !== 1'b0 || pending !== 3'd4) begin
            n_err++;
            $display("FAIL bp_full got=%b/%0d exp=0/4", wr_ready, pending);
        end
        repeat (2) nxt();
        vert = 10'd480;
        nxt();
        smp();
        n_cmp++;
        if (pending !== 3'd4 || wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_held got=%0d/%b exp=4/0", pending, wr_ready);
        end
        nxt();
        smp();
        n_cmp++;
        if (ram_we !== 1'b1 || wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_first_pop got=%b/%b exp=1/0", ram_we, wr_ready);
        end
        nxt();
        smp();
        n_cmp++;
        if (wr_ready !== 1'b1 || pending !== 3'd3) begin
            n_err++;
            $display("FAIL bp_ready got=%b/%0d exp=1/3", wr_ready, pending);
        end
        nxt();
        wr_valid = 1'b0;
        repeat (3) nxt();
        smp();
        n_cmp++;
        if (pending !== 3'd0 || upd_done !== 1'b1 || wq.size() != 0) begin
            n_err++;
            $display("FAIL bp_drain got=%0d/%b/%0d exp=0/1/0",
                     pending, upd_done, wq.size());
        end
        nxt();
        settle_active();
    endtask

    task automatic test_blank_end();
        int bad;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 11'h500 + 11'(i);
            wr_data  = 8'h70 + 8'(i);
            nxt();
        end
        wr_valid  = 1'b0;
        disp_req  = 1'b1;
        disp_addr = 11'h011;
        vert = 10'd480;
        repeat (4) nxt();
        vert = 10'd0;
        smp();
        n_cmp++;
        if (ram_we !== 1'b0 || pending !== 3'd4) begin
            n_err++;
            $display("FAIL bend_blocked got=%b/%0d exp=0/4", ram_we, pending);
        end
        nxt();
        disp_req = 1'b0;
        smp();
        n_cmp++;
        if (ram_we !== 1'b1 || ram_addr !== 11'h500) begin
            n_err++;
            $display("FAIL bend_one got=%b/%h exp=1/500", ram_we, ram_addr);
        end
        for (int i = 0; i < 4; i++) begin
            nxt();
            smp();
            if (ram_we !== 1'b0 || upd_done !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0 || pending !== 3'd3) begin
            n_err++;
            $display("FAIL bend_active got=%0d/%0d exp=0/3", bad, pending);
        end
        nxt();
        vert = 10'd480;
        repeat (5) nxt();
        smp();
        n_cmp++;
        if (upd_done !== 1'b1 || pending !== 3'd0 || wq.size() != 0) begin
            n_err++;
            $display("FAIL bend_next got=%b/%0d/%0d exp=1/0/0",
                     upd_done, pending, wq.size());
        end
        nxt();
        settle_active();
    endtask

    task automatic test_any_cycle();
        vert1 = 10'd200;
        repeat (3) nxt();
        wr_valid1 = 1'b1;
        wr_addr1  = 11'h055;
        wr_data1  = 8'h66;
        smp();
        n_cmp++;
        if (ram_we1 !== 1'b0 || frame_cnt1 !== 8'd0) begin
            n_err++;
            $display("FAIL any_idle got=%b/%0d exp=0/0", ram_we1, frame_cnt1);
        end
        nxt();
        wr_valid1 = 1'b0;
        smp();
        n_cmp++;
        if (ram_we1 !== 1'b1 || ram_addr1 !== 11'h055 ||
            ram_wdata1 !== 8'h66 || pending1 !== 3'd1) begin
            n_err++;
            $display("FAIL any_commit got=%b/%h/%h/%0d exp=1/055/66/1",
                     ram_we1, ram_addr1, ram_wdata1, pending1);
        end
        nxt();
        smp();
        n_cmp++;
        if (pending1 !== 3'd0 || upd_done1 !== 1'b0 || ram_we1 !== 1'b0) begin
            n_err++;
            $display("FAIL any_after got=%0d/%b/%b exp=0/0/0",
                     pending1, upd_done1, ram_we1);
        end
        nxt();
        for (int f = 0; f < 256; f++) begin
            vert1 = 10'd480;
            repeat (3) nxt();
            vert1 = 10'd100;
            repeat (3) nxt();
            if (f == 254) begin
                n_cmp++;
                if (frame_cnt1 !== 8'd255) begin
                    n_err++;
                    $display("FAIL any_frame255 got=%0d exp=255", frame_cnt1);
                end
            end
        end
        n_cmp++;
        if (frame_cnt1 !== 8'd0) begin
            n_err++;
            $display("FAIL any_wrap got=%0d exp=0", frame_cnt1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_priority();
        test_deferral();
        test_backpressure();
        test_blank_end();
        test_any_cycle();
        n_cmp++;
        if (wq.size() != 0 || rq.size() != 0) begin
            n_err++;
            $display("FAIL leftover got=%0d/%0d exp=0/0", wq.size(), rq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
